// File: rtl/rd_req_sched.sv
// rd_req_sched: read-request scheduler in front of the AXI bridge read port.
//
// Arbitrates icache, dcache and prefetcher read requests onto the single
// bridge read-request channel. Only one read is ever outstanding. The return
// pulse is routed back to whichever requester owns that read.
//
// Two mechanisms keep ordering and fairness:
//  - Reads that touch the line of an in-flight dcache write are held back until
//    that write's response arrives (read-after-write ordering).
//  - Starvation counters stop a steady stream of data reads from locking out
//    instruction fetch and prefetch.
//
// Ports
//   clk, resetn               clock, synchronous active-low reset
//   inst_req/type/addr        icache request (type 0 = single word, 1 = line burst)
//   inst_rdy                  icache request accepted this cycle (combinational)
//   inst_ret                  icache read data valid on bridge data bus (combinational)
//   data_*                    same set for the dcache
//   pf_*                      same set for the prefetcher
//   bus_rd_req/type/addr/id   registered request to the bridge (id 0=inst 1=data 2=pf)
//   bus_rd_rdy                bridge accepts the request
//   bus_ret_valid             bridge read return pulse
//   wr_fire, wr_addr          dcache write accepted by the bridge, and its address
//   wr_ok                     bridge write response pulse
module rd_req_sched #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned STARVE_W     = 4,
   parameter int unsigned LINE_OFF     = 4
) (
   input  logic        clk,
   input  logic        resetn,
   // icache
   input  logic        inst_req,
   input  logic        inst_type,
   input  logic [31:0] inst_addr,
   output logic        inst_rdy,
   output logic        inst_ret,
   // dcache
   input  logic        data_req,
   input  logic        data_type,
   input  logic [31:0] data_addr,
   output logic        data_rdy,
   output logic        data_ret,
   // prefetcher
   input  logic        pf_req,
   input  logic        pf_type,
   input  logic [31:0] pf_addr,
   output logic        pf_rdy,
   output logic        pf_ret,
   // bridge read channel
   output logic        bus_rd_req,
   output logic        bus_rd_type,
   output logic [31:0] bus_rd_addr,
   output logic [1:0]  bus_rd_id,
   input  logic        bus_rd_rdy,
   input  logic        bus_ret_valid,
   // dcache write tracking
   input  logic        wr_fire,
   input  logic [31:0] wr_addr,
   input  logic        wr_ok
);

   localparam int unsigned LINE_W = 32 - LINE_OFF;

   localparam logic [1:0] IdInst = 2'd0;
   localparam logic [1:0] IdData = 2'd1;
   localparam logic [1:0] IdPf   = 2'd2;

   localparam logic [STARVE_W-1:0] StarveLim = STARVE_W'(STARVE_LIMIT);
   localparam logic [STARVE_W-1:0] CntMax    = '1;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   state_e              state_q;
   logic [1:0]          id_q;
   logic                type_q;
   logic [31:0]         addr_q;
   logic                bus_req_q;
   logic                wr_pending_q;
   logic [LINE_W-1:0]   wr_line_q;
   logic [STARVE_W-1:0] inst_cnt_q;
   logic [STARVE_W-1:0] pf_cnt_q;

   // ------------------------------------------------------------------------
   // Eligibility: a request is blocked while a write to the same line is
   // outstanding. Uses the registered tracker, so a write fired this cycle
   // only blocks from the next cycle on.
   // ------------------------------------------------------------------------
   logic inst_haz, data_haz, pf_haz;
   logic inst_elig, data_elig, pf_elig;
   logic inst_starved, pf_starved;

   always_comb begin
      inst_haz  = wr_pending_q && (inst_addr[31:LINE_OFF] == wr_line_q);
      data_haz  = wr_pending_q && (data_addr[31:LINE_OFF] == wr_line_q);
      pf_haz    = wr_pending_q && (pf_addr[31:LINE_OFF] == wr_line_q);
      inst_elig = inst_req && !inst_haz;
      data_elig = data_req && !data_haz;
      pf_elig   = pf_req && !pf_haz;
      inst_starved = inst_cnt_q >= StarveLim;
      pf_starved   = pf_cnt_q >= StarveLim;
   end

   // ------------------------------------------------------------------------
   // Grant: one-hot, only in IDLE and never while reset is asserted.
   // Order: starved inst > starved pf > data > inst > pf.
   // ------------------------------------------------------------------------
   logic        gnt_inst, gnt_data, gnt_pf, gnt_any;
   logic [1:0]  gnt_id;
   logic        gnt_type;
   logic [31:0] gnt_addr;

   always_comb begin
      gnt_inst = 1'b0;
      gnt_data = 1'b0;
      gnt_pf   = 1'b0;
      if (resetn && (state_q == StIdle)) begin
         if (inst_elig && inst_starved) begin
            gnt_inst = 1'b1;
         end else if (pf_elig && pf_starved) begin
            gnt_pf = 1'b1;
         end else if (data_elig) begin
            gnt_data = 1'b1;
         end else if (inst_elig) begin
            gnt_inst = 1'b1;
         end else if (pf_elig) begin
            gnt_pf = 1'b1;
         end
      end
      gnt_any = gnt_inst | gnt_data | gnt_pf;
   end

   // Fields of the winning request, latched on grant.
   always_comb begin
      gnt_id   = IdPf;
      gnt_type = pf_type;
      gnt_addr = pf_addr;
      if (gnt_inst) begin
         gnt_id   = IdInst;
         gnt_type = inst_type;
         gnt_addr = inst_addr;
      end else if (gnt_data) begin
         gnt_id   = IdData;
         gnt_type = data_type;
         gnt_addr = data_addr;
      end
   end

   assign inst_rdy = gnt_inst;
   assign data_rdy = gnt_data;
   assign pf_rdy   = gnt_pf;

   // ------------------------------------------------------------------------
   // Return routing: only honoured in WAIT, only to the owner.
   // ------------------------------------------------------------------------
   logic ret_fire;

   always_comb begin
      ret_fire = resetn && (state_q == StWait) && bus_ret_valid;
      inst_ret = ret_fire && (id_q == IdInst);
      data_ret = ret_fire && (id_q == IdData);
      pf_ret   = ret_fire && (id_q == IdPf);
   end

   assign bus_rd_req  = bus_req_q;
   assign bus_rd_type = type_q;
   assign bus_rd_addr = addr_q;
   assign bus_rd_id   = id_q;

   // ------------------------------------------------------------------------
   // Starvation counters: count IDLE cycles spent eligible but losing.
   // A blocked (hazard) requester neither counts nor clears.
   // ------------------------------------------------------------------------
   function automatic logic [STARVE_W-1:0] cnt_next(
      input logic [STARVE_W-1:0] cnt,
      input logic                req,
      input logic                elig,
      input logic                gnt
   );
      if (!req || gnt) begin
         return '0;
      end else if (elig && (cnt != CntMax)) begin
         return cnt + 1'b1;
      end
      return cnt;
   endfunction

   logic [STARVE_W-1:0] inst_cnt_d, pf_cnt_d;

   always_comb begin
      inst_cnt_d = inst_cnt_q;
      pf_cnt_d   = pf_cnt_q;
      if (state_q == StIdle) begin
         inst_cnt_d = cnt_next(inst_cnt_q, inst_req, inst_elig, gnt_inst);
         pf_cnt_d   = cnt_next(pf_cnt_q, pf_req, pf_elig, gnt_pf);
      end
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= StIdle;
         id_q         <= 2'd0;
         type_q       <= 1'b0;
         addr_q       <= 32'd0;
         bus_req_q    <= 1'b0;
         wr_pending_q <= 1'b0;
         wr_line_q    <= '0;
         inst_cnt_q   <= '0;
         pf_cnt_q     <= '0;
      end else begin
         // A new write replaces the tracked line even if a response lands
         // in the same cycle.
         if (wr_fire) begin
            wr_pending_q <= 1'b1;
            wr_line_q    <= wr_addr[31:LINE_OFF];
         end else if (wr_ok) begin
            wr_pending_q <= 1'b0;
         end

         inst_cnt_q <= inst_cnt_d;
         pf_cnt_q   <= pf_cnt_d;

         case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  id_q      <= gnt_id;
                  type_q    <= gnt_type;
                  addr_q    <= gnt_addr;
                  bus_req_q <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               if (bus_rd_rdy) begin
                  bus_req_q <= 1'b0;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               if (bus_ret_valid) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               bus_req_q <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule
